led_pio_scheduler: RTL

Two-requester scheduler for the 8-bit LED PIO slave (s1) in the HDMI system. It takes LED update requests from two sources (e.g. CPU command path and game-of-life status logic) over valid/ready handshakes. It arbitrates round-robin and issues single-cycle Avalon-MM writes to PIO register 0, enforcing a minimum gap between writes. It sits between the requesters and the PIO, and is the only master that drives the PIO write port.

---
 rtl/led_pio_scheduler.sv | 120 ++++++++++++
 1 files changed

// File: rtl/led_pio_scheduler.sv
// Round-robin scheduler for two LED update requesters driving the single-write
// Avalon-MM port of the LED PIO, with a programmable idle gap after each write.
module led_pio_scheduler #(
  parameter int DATA_W  = 8,
  parameter int MIN_GAP = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [1:0]        pio_address,
  output logic              pio_chipselect,
  output logic              pio_write_n,
  output logic [31:0]       pio_writedata,
  output logic              owner,
  output logic              busy
);

  localparam int CNT_W = (MIN_GAP > 0) ? $clog2(MIN_GAP + 1) : 1;
  localparam logic [CNT_W-1:0] GAP_LOAD = (MIN_GAP > 0) ? CNT_W'(MIN_GAP - 1) : '0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [CNT_W-1:0]  gap_cnt;
  logic [CNT_W-1:0]  gap_cnt_next;
  logic              rr_last;
  logic              wr_idx;
  logic              grant;
  logic              accept;
  logic [DATA_W-1:0] latched;

  // Arbitration, handshake and next-state decode
  always_comb begin
    state_next   = state;
    gap_cnt_next = gap_cnt;
    accept       = 1'b0;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    // rr_last holds the requester granted most recently; the other one wins a tie
    if (req0_valid && req1_valid) begin
      grant = ~rr_last;
    end else if (req1_valid) begin
      grant = 1'b1;
    end else begin
      grant = 1'b0;
    end
    case (state)
      IDLE: begin
        if ((req0_valid || req1_valid) && !reset) begin
          accept     = 1'b1;
          req0_ready = ~grant;
          req1_ready = grant;
          state_next = WRITE;
        end else begin
          state_next = IDLE;
        end
      end
      WRITE: begin
        if (MIN_GAP == 0) begin
          state_next = IDLE;
        end else begin
          state_next   = GAP;
          gap_cnt_next = GAP_LOAD;
        end
      end
      GAP: begin
        if (gap_cnt == '0) begin
          state_next = IDLE;
        end else begin
          gap_cnt_next = gap_cnt - CNT_W'(1);
        end
      end
      default: begin
        state_next   = IDLE;
        gap_cnt_next = '0;
      end
    endcase
  end

  // State, gap counter, latched value and ownership registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      gap_cnt <= '0;
      rr_last <= 1'b1;
      wr_idx  <= 1'b0;
      owner   <= 1'b0;
      latched <= '0;
    end else begin
      state   <= state_next;
      gap_cnt <= gap_cnt_next;
      if (accept) begin
        latched <= grant ? req1_data : req0_data;
        wr_idx  <= grant;
      end
      if (state == WRITE) begin
        owner   <= wr_idx;
        rr_last <= wr_idx;
      end
    end
  end

  // Strobes decode straight from state so reset drops them without waiting for a clock
  assign pio_address    = 2'd0;
  assign pio_chipselect = (state == WRITE);
  assign pio_write_n    = (state != WRITE);
  assign pio_writedata  = 32'(latched);
  assign busy           = (state != IDLE);

endmodule
